// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the memory access stage and the control unit.
//  MEM_ADDR_W / MEM_DATA_W : main RAM word-address and data widths
//  MEM_DEPTH_DFLT          : implemented RAM words
//  MEM_WAIT_CYCLES         : extra RAM cycles per access, also used by control stall logic
//  mem_state_t             : memory access FSM states
package cpu_pkg;

  localparam int unsigned MEM_ADDR_W      = 9;
  localparam int unsigned MEM_DATA_W      = 32;
  localparam int unsigned MEM_DEPTH_DFLT  = 512;
  localparam int unsigned MEM_WAIT_CYCLES = 1;
  localparam int unsigned MEM_CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Memory access stage: converts level-held read/write strobes plus MAR/MDR
// contents into one timed access to synchronous RAM, with busy/done handshake.
// Optional macro MEM_ADDR_CHECK_EN: addresses >= MEM_DEPTH skip the RAM and
// complete with addr_err (reads return 0).
// Ports:
//  clk, reset            clock (rising), async active-high reset
//  read, write           held request strobes from the control unit
//  mar_addr, mdr_wdata   access address and store data
//  mdr_rdata, mdr_load   captured read data and its 1-cycle load pulse
//  mem_busy, mem_done    access in progress / 1-cycle completion pulse
//  addr_err              out-of-range completion flag
//  ram_en, ram_we, ram_addr, ram_wdata, ram_rdata   synchronous RAM port
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned DATA_W      = MEM_DATA_W,
  parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DFLT,
  parameter int unsigned WAIT_CYCLES = MEM_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] mdr_wdata,
  output logic [DATA_W-1:0] mdr_rdata,
  output logic              mdr_load,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              addr_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = MEM_CNT_W;

  // Elaboration-time parameter sanity
  if (MEM_DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("MEM_DEPTH exceeds address space");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES out of range 0..15");
  end

`ifdef MEM_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
`endif

  mem_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              armed, armed_nxt;
  logic              op_write, op_write_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_wdata_nxt, mdr_rdata_nxt;
  logic              ram_en_nxt, ram_we_nxt, busy_nxt, done_nxt, load_nxt, err_nxt;
  logic              addr_bad;

  // Range check on the incoming address (only meaningful in IDLE)
`ifdef MEM_ADDR_CHECK_EN
  assign addr_bad = ({1'b0, mar_addr} >= DEPTH_LIM);
`else
  assign addr_bad = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      armed     <= 1'b1;
      op_write  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      mdr_rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      mem_busy  <= 1'b0;
      mem_done  <= 1'b0;
      mdr_load  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      armed     <= armed_nxt;
      op_write  <= op_write_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_wdata <= ram_wdata_nxt;
      mdr_rdata <= mdr_rdata_nxt;
      ram_en    <= ram_en_nxt;
      ram_we    <= ram_we_nxt;
      mem_busy  <= busy_nxt;
      mem_done  <= done_nxt;
      mdr_load  <= load_nxt;
      addr_err  <= err_nxt;
    end
  end

  // Next state; outputs are computed for the upcoming state so they align with it
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    armed_nxt     = armed;
    op_write_nxt  = op_write;
    ram_addr_nxt  = ram_addr;
    ram_wdata_nxt = ram_wdata;
    mdr_rdata_nxt = mdr_rdata;
    ram_en_nxt    = 1'b0;
    ram_we_nxt    = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    load_nxt      = 1'b0;
    err_nxt       = 1'b0;

    // Re-arm only once both strobes have dropped: one held strobe, one access
    if (!read && !write) armed_nxt = 1'b1;

    unique case (state)
      IDLE: begin
        if (armed && (read || write)) begin
          armed_nxt     = 1'b0;
          op_write_nxt  = write;  // write wins over a simultaneous read
          ram_addr_nxt  = mar_addr;
          ram_wdata_nxt = mdr_wdata;
          cnt_nxt       = CNT_W'(WAIT_CYCLES);
          busy_nxt      = 1'b1;
          if (addr_bad) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
            load_nxt  = !write;
            if (!write) mdr_rdata_nxt = '0;
          end else begin
            state_nxt  = ACCESS;
            ram_en_nxt = 1'b1;
            ram_we_nxt = write;
          end
        end
      end
      ACCESS: begin
        busy_nxt = 1'b1;
        if (cnt == '0) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          load_nxt  = !op_write;
          if (!op_write) mdr_rdata_nxt = ram_rdata;
        end else begin
          cnt_nxt    = cnt - CNT_W'(1);
          ram_en_nxt = 1'b1;
          ram_we_nxt = op_write;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Four instances share the request inputs:
// main (WAIT=1, full RAM model), w0 (WAIT=0), w15 (WAIT=15), d256 (MEM_DEPTH=256).
// Latency indices count negedges after the accept edge (1 = first cycle after it).
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        read, write;
  logic [8:0]  mar_addr;
  logic [31:0] mdr_wdata;

  always #5 clk = ~clk;

  // main instance signals
  logic [31:0] m_mdr_rdata, m_ram_wdata, m_ram_rdata;
  logic [8:0]  m_ram_addr;
  logic        m_load, m_busy, m_done, m_err, m_en, m_we;
  // w0 instance
  logic [31:0] z_mdr_rdata, z_ram_wdata, z_ram_rdata;
  logic [8:0]  z_ram_addr;
  logic        z_load, z_busy, z_done, z_err, z_en, z_we;
  // w15 instance
  logic [31:0] f_mdr_rdata, f_ram_wdata, f_ram_rdata;
  logic [8:0]  f_ram_addr;
  logic        f_load, f_busy, f_done, f_err, f_en, f_we;
  // depth-256 instance
  logic [31:0] d_mdr_rdata, d_ram_wdata, d_ram_rdata;
  logic [8:0]  d_ram_addr;
  logic        d_load, d_busy, d_done, d_err, d_en, d_we;

  mem_access_unit #(.ADDR_W(9), .DATA_W(32), .MEM_DEPTH(512), .WAIT_CYCLES(1)) u_main (
    .clk(clk), .reset(reset), .read(read), .write(write), .mar_addr(mar_addr),
    .mdr_wdata(mdr_wdata), .mdr_rdata(m_mdr_rdata), .mdr_load(m_load), .mem_busy(m_busy),
    .mem_done(m_done), .addr_err(m_err), .ram_en(m_en), .ram_we(m_we),
    .ram_addr(m_ram_addr), .ram_wdata(m_ram_wdata), .ram_rdata(m_ram_rdata));

  mem_access_unit #(.ADDR_W(9), .DATA_W(32), .MEM_DEPTH(512), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .read(read), .write(write), .mar_addr(mar_addr),
    .mdr_wdata(mdr_wdata), .mdr_rdata(z_mdr_rdata), .mdr_load(z_load), .mem_busy(z_busy),
    .mem_done(z_done), .addr_err(z_err), .ram_en(z_en), .ram_we(z_we),
    .ram_addr(z_ram_addr), .ram_wdata(z_ram_wdata), .ram_rdata(z_ram_rdata));

  mem_access_unit #(.ADDR_W(9), .DATA_W(32), .MEM_DEPTH(512), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .reset(reset), .read(read), .write(write), .mar_addr(mar_addr),
    .mdr_wdata(mdr_wdata), .mdr_rdata(f_mdr_rdata), .mdr_load(f_load), .mem_busy(f_busy),
    .mem_done(f_done), .addr_err(f_err), .ram_en(f_en), .ram_we(f_we),
    .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata), .ram_rdata(f_ram_rdata));

  mem_access_unit #(.ADDR_W(9), .DATA_W(32), .MEM_DEPTH(256), .WAIT_CYCLES(1)) u_d256 (
    .clk(clk), .reset(reset), .read(read), .write(write), .mar_addr(mar_addr),
    .mdr_wdata(mdr_wdata), .mdr_rdata(d_mdr_rdata), .mdr_load(d_load), .mem_busy(d_busy),
    .mem_done(d_done), .addr_err(d_err), .ram_en(d_en), .ram_we(d_we),
    .ram_addr(d_ram_addr), .ram_wdata(d_ram_wdata), .ram_rdata(d_ram_rdata));

  // Secondary instances: combinational address-pattern RAM, valid whenever enabled
  assign z_ram_rdata = z_en ? (32'hC0DE0000 | 32'(z_ram_addr)) : 32'h0;
  assign f_ram_rdata = f_en ? (32'hC0DE0000 | 32'(f_ram_addr)) : 32'h0;
  assign d_ram_rdata = d_en ? (32'hC0DE0000 | 32'(d_ram_addr)) : 32'h0;

  // Main RAM model (ram_sync_512x32 behaviour, WAIT=1): read data one cycle after
  // address, write committed only when we is held for the full 2-cycle access
  logic [31:0] ram [512];
  logic [31:0] rd_pipe;
  int          we_run;
  logic        pre_we = 1'b0;
  logic [8:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (m_en && m_we && we_run == 1) ram[m_ram_addr] <= m_ram_wdata;
    we_run  <= (m_en && m_we) ? we_run + 1 : 0;
    rd_pipe <= ram[m_ram_addr];
  end
  assign m_ram_rdata = rd_pipe;

  int checks = 0;
  int failures = 0;

  // Per-access observations
  int m_done_idx, m_done_cnt, m_load_cnt, m_load_idx, m_en_cnt, m_we_cnt;
  int z_done_idx, f_done_idx, d_done_idx, d_err_idx, d_en_cnt, d_load_cnt;

  task automatic ram_poke(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_we = 1'b0;
  endtask

  // Present a request, hold it for 'hold' cycles, observe 22 cycles
  task automatic run_access(input logic rd, input logic wr, input logic [8:0] addr,
                            input logic [31:0] wd, input int hold, input logic [8:0] alt_addr);
    m_done_idx = 0; m_done_cnt = 0; m_load_cnt = 0; m_load_idx = 0; m_en_cnt = 0; m_we_cnt = 0;
    z_done_idx = 0; f_done_idx = 0; d_done_idx = 0; d_err_idx = 0; d_en_cnt = 0; d_load_cnt = 0;
    @(negedge clk); read = rd; write = wr; mar_addr = addr; mdr_wdata = wd;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (m_done && m_done_idx == 0) m_done_idx = i;
      if (m_load) begin m_load_cnt++; m_load_idx = i; end
      m_done_cnt += int'(m_done); m_en_cnt += int'(m_en); m_we_cnt += int'(m_we);
      if (z_done && z_done_idx == 0) z_done_idx = i;
      if (f_done && f_done_idx == 0) f_done_idx = i;
      if (d_done && d_done_idx == 0) d_done_idx = i;
      if (d_err && d_err_idx == 0) d_err_idx = i;
      d_en_cnt += int'(d_en); d_load_cnt += int'(d_load);
      if (i == 1) mar_addr = alt_addr;
      if (i == hold) begin read = 1'b0; write = 1'b0; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; read = 1'b0; write = 1'b0; mar_addr = '0; mdr_wdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (m_mdr_rdata !== 32'h0) begin failures++; $display("FAIL reset_mdr_rdata got=%h exp=0", m_mdr_rdata); end
    checks++; if ({m_load, m_busy, m_done, m_err, m_en, m_we} !== 6'b0) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {m_load, m_busy, m_done, m_err, m_en, m_we}); end
    checks++; if ({m_ram_addr, m_ram_wdata} !== 41'h0) begin failures++;
      $display("FAIL reset_ram_bus got=%h/%h exp=0/0", m_ram_addr, m_ram_wdata); end
    reset = 1'b0;
    ram_poke(9'h005, 32'hDEADBEEF);
    ram_poke(9'h006, 32'h66666666);
    ram_poke(9'h000, 32'h00000000);
    ram_poke(9'h1FF, 32'h00000000);
    ram_poke(9'h020, 32'h11111111);
  endtask

  task automatic test_read();
    run_access(1'b1, 1'b0, 9'h005, 32'h0, 6, 9'h006);
    checks++; if (m_done_idx !== 3) begin failures++; $display("FAIL read_latency got=%0d exp=3", m_done_idx); end
    checks++; if (m_mdr_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data got=%h exp=deadbeef", m_mdr_rdata); end
    checks++; if (m_load_cnt !== 1 || m_load_idx !== 3) begin failures++;
      $display("FAIL read_mdr_load got=cnt%0d@%0d exp=cnt1@3", m_load_cnt, m_load_idx); end
    checks++; if (m_done_cnt !== 1 || m_en_cnt !== 2) begin failures++;
      $display("FAIL read_single_access got=done%0d/en%0d exp=done1/en2", m_done_cnt, m_en_cnt); end
  endtask

  task automatic test_write_read();
    run_access(1'b0, 1'b1, 9'h1F0, 32'h12345678, 3, 9'h1F0);
    checks++; if (m_we_cnt !== 2) begin failures++; $display("FAIL write_we_cycles got=%0d exp=2", m_we_cnt); end
    checks++; if (m_load_cnt !== 0 || m_done_idx !== 3) begin failures++;
      $display("FAIL write_done got=load%0d/lat%0d exp=load0/lat3", m_load_cnt, m_done_idx); end
    checks++; if (ram[9'h1F0] !== 32'h12345678) begin failures++; $display("FAIL write_ram got=%h exp=12345678", ram[9'h1F0]); end
    checks++; if (m_mdr_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL write_keeps_mdr got=%h exp=deadbeef", m_mdr_rdata); end
    run_access(1'b1, 1'b0, 9'h1F0, 32'h0, 3, 9'h1F0);
    checks++; if (m_mdr_rdata !== 32'h12345678) begin failures++; $display("FAIL readback got=%h exp=12345678", m_mdr_rdata); end
  endtask

  task automatic test_read_write_collision();
    run_access(1'b1, 1'b1, 9'h010, 32'hA5A5A5A5, 3, 9'h010);
    checks++; if (m_load_cnt !== 0) begin failures++; $display("FAIL rw_no_load got=%0d exp=0", m_load_cnt); end
    checks++; if (ram[9'h010] !== 32'hA5A5A5A5) begin failures++; $display("FAIL rw_write_wins got=%h exp=a5a5a5a5", ram[9'h010]); end
    checks++; if (m_mdr_rdata !== 32'h12345678) begin failures++; $display("FAIL rw_mdr_kept got=%h exp=12345678", m_mdr_rdata); end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk); write = 1'b1; mar_addr = 9'h020; mdr_wdata = 32'h0BADF00D;
    @(negedge clk);
    checks++; if ({m_en, m_we, m_busy} !== 3'b111) begin failures++; $display("FAIL abort_pre got=%b exp=111", {m_en, m_we, m_busy}); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({m_en, m_we, m_busy} !== 3'b000) begin failures++; $display("FAIL abort_async got=%b exp=000", {m_en, m_we, m_busy}); end
    write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ram[9'h020] !== 32'h11111111) begin failures++; $display("FAIL abort_ram got=%h exp=11111111", ram[9'h020]); end
    checks++; if (m_mdr_rdata !== 32'h0 || m_done !== 1'b0) begin failures++;
      $display("FAIL abort_idle got=%h/%b exp=0/0", m_mdr_rdata, m_done); end
  endtask

  task automatic test_addr_check();
    run_access(1'b1, 1'b0, 9'h1FF, 32'h0, 3, 9'h1FF);
`ifdef MEM_ADDR_CHECK_EN
    checks++; if (d_en_cnt !== 0) begin failures++; $display("FAIL oor_no_ram got=%0d exp=0", d_en_cnt); end
    checks++; if (d_done_idx !== 1 || d_err_idx !== 1) begin failures++;
      $display("FAIL oor_latency got=done%0d/err%0d exp=1/1", d_done_idx, d_err_idx); end
    checks++; if (d_mdr_rdata !== 32'h0 || d_load_cnt !== 1) begin failures++;
      $display("FAIL oor_data got=%h/load%0d exp=0/1", d_mdr_rdata, d_load_cnt); end
`else
    checks++; if (d_en_cnt !== 2 || d_err_idx !== 0) begin failures++;
      $display("FAIL nochk_ram got=en%0d/err%0d exp=2/0", d_en_cnt, d_err_idx); end
    checks++; if (d_done_idx !== 3 || d_mdr_rdata !== 32'hC0DE01FF) begin failures++;
      $display("FAIL nochk_read got=lat%0d/%h exp=3/c0de01ff", d_done_idx, d_mdr_rdata); end
`endif
    checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL inrange_err got=%b exp=0", m_err); end
  endtask

  task automatic test_wait_sweep();
    run_access(1'b1, 1'b0, 9'h000, 32'h0, 4, 9'h000);
    checks++; if (z_done_idx !== 2) begin failures++; $display("FAIL wait0_latency got=%0d exp=2", z_done_idx); end
    checks++; if (f_done_idx !== 17) begin failures++; $display("FAIL wait15_latency got=%0d exp=17", f_done_idx); end
    checks++; if (m_done_idx !== 3) begin failures++; $display("FAIL wait1_latency got=%0d exp=3", m_done_idx); end
    checks++; if (z_mdr_rdata !== 32'hC0DE0000 || f_mdr_rdata !== 32'hC0DE0000) begin failures++;
      $display("FAIL sweep_data got=%h/%h exp=c0de0000", z_mdr_rdata, f_mdr_rdata); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_read_write_collision();
    test_reset_mid_write();
    test_addr_check();
    test_wait_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
